// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq: IF-stage PC sequencer, one outstanding imem request.
// Build option DELAY_SLOT_EN delivers the redirect slot instead of squashing it.
module pc_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_D,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr_F,
    output logic [31:0] pc_F,
    output logic        valid_F,
    output logic        fetch_busy,
    output logic        align_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state;
    logic [31:0] fpc;
    logic        pend_v;
    logic [31:0] pend_pc;

    logic        in_req;
    logic        ack;
    logic        redir;
    logic        squash;
    logic [31:0] tgt;
    logic [31:0] seq_pc;

    assign in_req = (state == REQ);
    assign ack    = in_req & imem_ack;
    assign redir  = redirect_valid & ~stall_D;
    assign tgt    = {redirect_pc[31:2], 2'b00};
    assign seq_pc = fpc + 32'd4;

    // The slot is the fetch in flight when the redirect is honored,
    // either already pending or arriving on the ack cycle itself.
`ifdef DELAY_SLOT_EN
    assign squash = 1'b0;
`else
    assign squash = redir | pend_v;
`endif

    assign imem_req   = in_req;
    assign imem_addr  = fpc;
    assign fetch_busy = in_req & ~imem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            pend_v    <= 1'b0;
            pend_pc   <= RESET_PC;
            pc_F      <= RESET_PC;
            instr_F   <= 32'd0;
            valid_F   <= 1'b0;
            align_err <= 1'b0;
        end else begin
            if (redir && (redirect_pc[1:0] != 2'b00)) begin
                align_err <= 1'b1;
            end

            // Decode consumes the F output on any unstalled cycle.
            if (ack) begin
                instr_F <= imem_rdata;
                pc_F    <= fpc;
                valid_F <= ~squash;
            end else if (!stall_D) begin
                valid_F <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    state <= REQ;
                    if (redir) begin
                        fpc <= tgt;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        state  <= stall_D ? HOLD : REQ;
                        pend_v <= 1'b0;
                        if (redir) begin
                            fpc <= tgt;
                        end else if (pend_v) begin
                            fpc <= pend_pc;
                        end else begin
                            fpc <= seq_pc;
                        end
                    end else if (redir) begin
                        pend_v  <= 1'b1;
                        pend_pc <= tgt;
                    end
                end
                HOLD: begin
                    if (!stall_D) begin
                        state <= REQ;
                        if (redir) begin
                            fpc <= tgt;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
